// File: rtl/full_adder_p_bit_reg_if.sv
// Purpose: operand/result bundle for the P-bit registered ripple-carry adder.
// Latency: n/a (wiring only); results appear one cycle after their operands.
// Backpressure: none; valid-only tagging, the adder accepts one set per cycle.
interface full_adder_p_bit_reg_if #(
  parameter int P = 4
) ();
  logic [P-1:0] A;
  logic [P-1:0] B;
  logic         Cin;
  logic         in_valid;
  logic [P-1:0] Sum;
  logic         Cout;
  logic         out_valid;

  // Producer side: drives operands, observes results.
  modport master (
    output A, B, Cin, in_valid,
    input  Sum, Cout, out_valid
  );

  // Adder side: consumes operands, drives registered results.
  modport slave (
    input  A, B, Cin, in_valid,
    output Sum, Cout, out_valid
  );
endinterface

// File: rtl/full_adder_p_bit_reg.sv
// Purpose: P-bit ripple-carry adder {Cout,Sum} = A + B + Cin with registered result.
// Latency: 1 cycle from in_valid to out_valid; fully pipelined, one add per cycle.
// Backpressure: none; results are tagged by out_valid and Sum/Cout hold when idle.
module full_adder_p_bit_reg #(
  parameter int P = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  full_adder_p_bit_reg_if.slave bus
);

  logic [P-1:0] sum_comb;
  logic         cout_comb;

  // One full-adder cell per bit, each built from two half adders and an OR.
  // Per-cell carry signals keep the chain free of self-referencing vectors.
  for (genvar i = 0; i < P; i++) begin : g_cell
    logic ci;
    logic co;
    logic ha0_s;
    logic ha0_c;
    logic ha1_s;
    logic ha1_c;

    if (i == 0) begin : g_first
      assign ci = bus.Cin;
    end else begin : g_next
      assign ci = g_cell[i-1].co;
    end

    // First half adder: the operand bits.
    assign ha0_s = bus.A[i] ^ bus.B[i];
    assign ha0_c = bus.A[i] & bus.B[i];

    // Second half adder: partial sum plus incoming carry.
    assign ha1_s = ha0_s ^ ci;
    assign ha1_c = ha0_s & ci;

    assign sum_comb[i] = ha1_s;
    assign co          = ha0_c | ha1_c;
  end

  assign cout_comb = g_cell[P-1].co;

  // Result register: reset clears everything and wins over in_valid;
  // idle cycles keep the last result but drop the valid tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.Sum       <= '0;
      bus.Cout      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.Sum       <= sum_comb;
      bus.Cout      <= cout_comb;
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder_p_bit_reg.sv
// Bench for the registered ripple-carry adder at P = 1, 4 and 8: directed
// steps on the 4-bit instance, then random vectors on all three against an
// arithmetic model of A + B + Cin with one cycle of delay.
module tb_full_adder_p_bit_reg;

  logic clk;
  logic rst_n;

  int pass_cnt;
  int total_cnt;

  full_adder_p_bit_reg_if #(.P(1)) f1 ();
  full_adder_p_bit_reg_if #(.P(4)) f4 ();
  full_adder_p_bit_reg_if #(.P(8)) f8 ();

  full_adder_p_bit_reg #(.P(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(f1.slave));
  full_adder_p_bit_reg #(.P(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(f4.slave));
  full_adder_p_bit_reg #(.P(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(f8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: the full P+1-bit result and its valid tag per instance.
  int res1, res4, res8;
  bit vld1, vld4, vld8;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge; the model sees the same inputs the DUTs sample.
  task automatic tick();
    int n1, n4, n8;
    bit v1, v4, v8;
    n1 = res1; n4 = res4; n8 = res8;
    v1 = 0; v4 = 0; v8 = 0;
    if (!rst_n) begin
      n1 = 0; n4 = 0; n8 = 0;
    end else begin
      if (f1.in_valid) begin n1 = int'(f1.A) + int'(f1.B) + int'(f1.Cin); v1 = 1; end
      if (f4.in_valid) begin n4 = int'(f4.A) + int'(f4.B) + int'(f4.Cin); v4 = 1; end
      if (f8.in_valid) begin n8 = int'(f8.A) + int'(f8.B) + int'(f8.Cin); v8 = 1; end
    end
    @(posedge clk);
    #1;
    res1 = n1; res4 = n4; res8 = n8;
    vld1 = v1; vld4 = v4; vld8 = v8;
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    f4.in_valid = v;
    f4.A        = a;
    f4.B        = b;
    f4.Cin      = c;
  endtask

  // Directed check of the 4-bit instance against literal expectations.
  task automatic check4(input string tag, input logic [4:0] exp_res, input logic exp_vld);
    check({tag, "_res"}, 16'({f4.Cout, f4.Sum}), 16'(exp_res));
    check({tag, "_vld"}, 16'(f4.out_valid), 16'(exp_vld));
  endtask

  logic [3:0] basic_a [5] = '{4'd3, 4'd1, 4'd3, 4'd2, 4'd0};
  logic [3:0] basic_b [5] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd3};
  logic [4:0] basic_s [5] = '{5'b0_0100, 5'b0_0011, 5'b0_0110, 5'b0_0011, 5'b0_0011};

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    res1 = 0; res4 = 0; res8 = 0;
    vld1 = 0; vld4 = 0; vld8 = 0;

    f1.in_valid = 0; f1.A = '0; f1.B = '0; f1.Cin = 0;
    f8.in_valid = 0; f8.A = '0; f8.B = '0; f8.Cin = 0;

    // Reset held for two edges with a valid all-ones input present.
    rst_n = 0;
    drive4(1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    tick();
    check4("reset", 5'b0_0000, 1'b0);
    check("reset_p1_vld", 16'(f1.out_valid), 16'd0);
    check("reset_p8_vld", 16'(f8.out_valid), 16'd0);

    // Back-to-back basic sums, each visible right after its edge.
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, basic_a[i], basic_b[i], 1'b0);
      tick();
      check4($sformatf("basic%0d", i), basic_s[i], 1'b1);
    end

    // Carry out of the top bit.
    drive4(1'b1, 4'b1111, 4'b0001, 1'b0);
    tick();
    check4("carry_f_1", 5'b1_0000, 1'b1);
    drive4(1'b1, 4'b1111, 4'b1111, 1'b1);
    tick();
    check4("carry_f_f_1", 5'b1_1111, 1'b1);

    // Carry rippling from Cin through bits 0..2 into bit 3.
    drive4(1'b1, 4'b0111, 4'b0000, 1'b1);
    tick();
    check4("ripple", 5'b0_1000, 1'b1);

    // Hold: result stays while operands toggle with in_valid low.
    drive4(1'b1, 4'd5, 4'd2, 1'b0);
    tick();
    check4("hold_load", 5'b0_0111, 1'b1);
    drive4(1'b0, 4'hA, 4'h5, 1'b1);
    tick();
    check4("hold_1", 5'b0_0111, 1'b0);
    drive4(1'b0, 4'h5, 4'hA, 1'b0);
    tick();
    check4("hold_2", 5'b0_0111, 1'b0);

    // Reset coinciding with a valid input discards it.
    rst_n = 0;
    drive4(1'b1, 4'd6, 4'd6, 1'b0);
    tick();
    check4("rst_mid", 5'b0_0000, 1'b0);
    rst_n = 1;
    tick();
    check4("rst_after", 5'b0_1100, 1'b1);

    // Random vectors on all three widths with occasional idles and resets.
    for (int n = 0; n < 1000; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      f1.in_valid = ($urandom_range(0, 3) != 0);
      f1.A = 1'($urandom); f1.B = 1'($urandom); f1.Cin = 1'($urandom);
      f4.in_valid = ($urandom_range(0, 3) != 0);
      f4.A = 4'($urandom); f4.B = 4'($urandom); f4.Cin = 1'($urandom);
      f8.in_valid = ($urandom_range(0, 3) != 0);
      f8.A = 8'($urandom); f8.B = 8'($urandom); f8.Cin = 1'($urandom);
      tick();
      check("rand_p1_res", 16'({f1.Cout, f1.Sum}), 16'(res1));
      check("rand_p1_vld", 16'(f1.out_valid), 16'(vld1));
      check("rand_p4_res", 16'({f4.Cout, f4.Sum}), 16'(res4));
      check("rand_p4_vld", 16'(f4.out_valid), 16'(vld4));
      check("rand_p8_res", 16'({f8.Cout, f8.Sum}), 16'(res8));
      check("rand_p8_vld", 16'(f8.out_valid), 16'(vld8));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
